// File: rtl/instruction_fetch_unit_pkg.sv
// Shared constants and types for the instruction fetch stage.
package instruction_fetch_unit_pkg;

    localparam logic [31:0] NOP_INSTR   = 32'h00000013;
    localparam int          PC_INCR     = 4;
    localparam int          IMEM_ADDR_W = 9;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/instruction_fetch_unit_fetch_pc_gen.sv
// Program counter register with next-PC priority: branch redirect, stall hold, sequential advance.
module fetch_pc_gen
    import instruction_fetch_unit_pkg::*;
#(
    parameter int                ADDR_W   = IMEM_ADDR_W,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              run,
    input  logic              stall,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_target,
    output logic [ADDR_W-1:0] pc,
    output logic              misaligned
);

    logic [ADDR_W-1:0] pc_next;

    assign misaligned = branch_taken && (branch_target[1:0] != 2'b00);

    // Redirects always land word-aligned; a misaligned target is truncated on its way to HALT.
    always_comb begin
        pc_next = pc;
        if (run) begin
            if (branch_taken) begin
                pc_next = {branch_target[ADDR_W-1:2], 2'b00};
            end else if (!stall) begin
                pc_next = pc + ADDR_W'(PC_INCR);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= RESET_PC;
        end else begin
            pc <= pc_next;
        end
    end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: sequencing FSM, IF/ID pipeline register and fetch counter around fetch_pc_gen.
//   state | meaning
//   BOOT  | first edge after reset; pc holds, IF/ID gets a bubble
//   RUN   | normal fetch with branch/stall/flush priority
//   HALT  | misaligned branch seen; pc frozen, bubbles only, until reset
module instruction_fetch_unit
    import instruction_fetch_unit_pkg::*;
#(
    parameter int                ADDR_W   = IMEM_ADDR_W,
    parameter int                DATA_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic              flush,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_target,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [DATA_W-1:0] imem_instr,
    output logic [DATA_W-1:0] if_id_instr,
    output logic [ADDR_W-1:0] if_id_pc,
    output logic              if_id_valid,
    output logic              fetch_fault,
    output logic [31:0]       fetch_count
);

    fetch_state_t      state;
    fetch_state_t      state_next;
    logic [ADDR_W-1:0] pc;
    logic              misaligned;
    logic              ifid_load;
    logic              ifid_bubble;

    fetch_pc_gen #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (RESET_PC)
    ) u_pc_gen (
        .clk           (clk),
        .rst_n         (rst_n),
        .run           (state == RUN),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .pc            (pc),
        .misaligned    (misaligned)
    );

    assign imem_addr = pc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= BOOT;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            BOOT:    state_next = RUN;
            RUN:     if (misaligned) state_next = HALT;
            HALT:    state_next = HALT;
            default: state_next = BOOT;
        endcase
    end

    // HALT is only reachable through a misaligned branch, so the sticky fault is the state itself.
    always_comb begin
        ifid_load   = 1'b0;
        ifid_bubble = 1'b0;
        fetch_fault = (state == HALT);
        case (state)
            RUN: begin
                if (branch_taken) begin
                    ifid_bubble = 1'b1;
                end else if (stall) begin
                    ifid_bubble = flush;
                end else if (flush) begin
                    ifid_bubble = 1'b1;
                end else begin
                    ifid_load = 1'b1;
                end
            end
            default: ifid_bubble = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            if_id_instr <= DATA_W'(NOP_INSTR);
            if_id_pc    <= '0;
            if_id_valid <= 1'b0;
            fetch_count <= '0;
        end else if (ifid_bubble) begin
            if_id_instr <= DATA_W'(NOP_INSTR);
            if_id_pc    <= '0;
            if_id_valid <= 1'b0;
        end else if (ifid_load) begin
            if_id_instr <= imem_instr;
            if_id_pc    <= pc;
            if_id_valid <= 1'b1;
            fetch_count <= fetch_count + 32'd1;
        end
    end

endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
Fetch stage that sits directly upstream of the byte-addressed instruction ROM.
- Owns the program counter and drives the ROM address.
- Captures the returned 32-bit little-endian word into the IF/ID pipeline register for decode.
- Handles stall, flush, branch redirect, misaligned-target fault and a fetch counter.

Parameters:
ADDR_W, 9, byte-address width; matches instruction ROM depth of 512 bytes
DATA_W, 32, instruction width
RESET_PC, 0, PC value loaded on reset; must be word-aligned

Ports:
clk  input  1  single clock; all state updates on rising edge
rst_n  input  1  asynchronous, active-low reset
stall  input  1  hold PC and IF/ID contents
flush  input  1  replace IF/ID contents with a bubble
branch_taken  input  1  redirect PC to branch_target
branch_target  input  ADDR_W  redirect byte address
imem_addr  output  ADDR_W  byte address to instruction ROM; equals PC, combinational
imem_instr  input  DATA_W  word returned combinationally by ROM for imem_addr
if_id_instr  output  DATA_W  registered instruction to decode
if_id_pc  output  ADDR_W  registered PC of if_id_instr
if_id_valid  output  1  if_id_instr is a real fetched instruction
fetch_fault  output  1  sticky; misaligned branch target seen
fetch_count  output  32  number of valid instructions loaded into IF/ID

Behaviour:
- Reset (async assert, any time including mid-operation):
  - pc=RESET_PC, state=BOOT.
  - if_id_instr=NOP (0x00000013), if_id_pc=0, if_id_valid=0.
  - fetch_fault=0, fetch_count=0.
- FSM states: BOOT, RUN, HALT.
  - BOOT → RUN unconditionally after one edge. In BOOT: pc holds and IF/ID loads a bubble.
  - RUN → HALT when branch_taken=1 and branch_target[1:0]≠0.
  - HALT is left only by reset. In HALT: pc frozen, IF/ID loads a bubble every edge, fetch_fault=1.
- RUN per-edge priority (highest first):
  1. branch_taken, aligned target: pc←branch_target; IF/ID←bubble; stall ignored.
  2. branch_taken, misaligned target: pc←branch_target with bits[1:0] cleared; IF/ID←bubble; fetch_fault←1; state←HALT.
  3. stall=1: pc holds. If flush=1, IF/ID←bubble; else IF/ID holds.
  4. flush=1: IF/ID←bubble; pc←pc+4.
  5. Normal: IF/ID←{imem_instr, pc, valid=1}; pc←pc+4; fetch_count+1.
- Bubble definition: instr=NOP, pc=0, valid=0. A bubble never increments fetch_count.
- Latency: the word at address A appears on if_id_instr one edge after imem_addr=A in RUN with no stall.
- After reset release: first valid fetch (RESET_PC) reaches IF/ID on the 2nd edge.
- PC arithmetic is modulo 2^ADDR_W: pc=508 → next 0. fetch_count wraps at 2^32.
- imem_addr is driven straight from the pc register, with no combinational path from inputs.

Decomposition:
- Shared package holds:
  - NOP_INSTR = 32'h00000013
  - fetch_state_t enum {BOOT, RUN, HALT}
  - PC_INCR = 4
  - IMEM_ADDR_W = 9
- One natural sub-module, fetch_pc_gen:
  - Contains the pc register plus next-PC priority mux.
  - Outputs pc and the misaligned flag.
  - The top level holds the FSM, IF/ID register and counter.

Test Plan:
1. Reset, release, ROM words 0..3 = I0..I3, no stall.
   - Edge1: valid=0.
   - Edges 2..5: if_id_instr=I0..I3, if_id_pc=0,4,8,12, fetch_count=4.
2. Stall high for 3 edges while pc=8.
   - imem_addr stays 8; IF/ID holds I1/pc 4; fetch_count unchanged.
   - After release: I2 at pc 8.
3. branch_taken with target 0x40 at pc=12.
   - Next edge: pc=0x40, if_id_valid=0.
   - Following edge: instruction at 0x40, if_id_pc=0x40.
4. Run to pc=508 → next imem_addr=0; if_id_pc=508 loaded with valid=1.
5. branch_taken with target 0x42.
   - pc=0x40, fetch_fault=1, state HALT.
   - All later edges: valid=0, pc frozen, regardless of stall/flush/branch, until rst_n=0.
6. Assert rst_n low asynchronously mid-cycle while stall=1, flush=1.
   - Outputs return to reset values immediately, without waiting for an edge.
   - flush+stall before reset: IF/ID=bubble, pc held.
